div_unit_param: RTL and testbench

Parametrised iterative integer divider for the execute stage, successor to the fixed 32-bit divide unit. It performs RISC-V DIV/DIVU/REM/REMU at a configurable operand width using a radix-2 restoring datapath with optional leading-zero early termination. It accepts one request through the standard issue handshake and holds each result under writeback back-pressure until acknowledged. It supports result reuse and a pipeline flush.

---
 rtl/div_unit_param.sv | 236 +++++++++++++++++++++++
 tb/tb_div_unit_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit_param.sv
// div_unit_param
// Parametrised radix-2 restoring divider for the execute stage. Handles
// DIV/DIVU/REM/REMU at WIDTH bits, optionally skipping iterations that only
// shift leading zeros of the dividend magnitude. One request in flight; the
// result is held on the writeback port until acknowledged. The last computed
// quotient/remainder pair is kept so a repeat request can skip the divide.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   new_request       issue valid
//   ready             issue ready: idle and not flushing
//   rs1, rs2          dividend, divisor
//   op                00 DIV, 01 DIVU, 10 REM, 11 REMU
//   reuse_result      return the stored result instead of dividing
//   instruction_id    tag, echoed on wb_id
//   flush             synchronous abort of any in-flight op
//   wb_done           result valid (held until wb_ack)
//   wb_rd, wb_id      result and its tag
//   wb_ack            writeback accepted
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a request, ready=1
// INIT      | operand magnitudes, iteration count, dividend pre-shift
// DIVIDE    | one quotient bit per cycle, counter runs down to 1
// SIGN_FIX  | apply signs / divide-by-zero rule, update reuse registers
// DONE      | wb_done=1, waiting for wb_ack

module div_unit_param #(
  parameter int WIDTH           = 32,
  parameter int ID_W            = 3,
  parameter int EARLY_TERMINATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_request,
  output logic             ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [1:0]       op,
  input  logic             reuse_result,
  input  logic [ID_W-1:0]  instruction_id,
  input  logic             flush,
  output logic             wb_done,
  output logic [WIDTH-1:0] wb_rd,
  output logic [ID_W-1:0]  wb_id,
  input  logic             wb_ack
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INIT     = 3'd1;
  localparam logic [2:0] S_DIVIDE   = 3'd2;
  localparam logic [2:0] S_SIGN_FIX = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // Number of leading zeros; returns WIDTH for an all-zero input.
  function automatic logic [CNT_W-1:0] count_lz(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n = CNT_W'(WIDTH - 1 - i);
    end
    return n;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits out the top, quotient bits in the bottom
  logic [WIDTH-1:0] dsr_q, dsr_d;   // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, always < divisor
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [ID_W-1:0]  wb_id_q, wb_id_d;
  logic [WIDTH-1:0] stored_quo_q, stored_quo_d;
  logic [WIDTH-1:0] stored_rem_q, stored_rem_d;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_zero;
  logic             b_zero;
  logic [CNT_W-1:0] lz;
  logic [CNT_W-1:0] n_iter;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign ready   = (state_q == S_IDLE) & ~flush;
  assign wb_done = (state_q == S_DONE) & ~flush;
  assign wb_rd   = wb_rd_q;
  assign wb_id   = wb_id_q;

  // Operand conditioning, valid from INIT onward (operands are held).
  // Negating MIN gives MIN, which read unsigned is exactly |MIN|, so the
  // overflow case MIN / -1 falls out of the magnitude path unaided.
  assign signed_op = ~op_q[0];
  assign a_neg     = signed_op & a_q[WIDTH-1];
  assign b_neg     = signed_op & b_q[WIDTH-1];
  assign a_mag     = a_neg ? -a_q : a_q;
  assign b_mag     = b_neg ? -b_q : b_q;
  assign a_zero    = (a_mag == '0);
  assign b_zero    = (b_q == '0);
  assign lz        = (EARLY_TERMINATE != 0) ? count_lz(a_mag) : '0;
  // A zero dividend or zero divisor needs no iterations in either mode;
  // the quotient/remainder registers already hold the right answer (0/0)
  // or are overridden by the divide-by-zero rule.
  assign n_iter    = (a_zero | b_zero) ? '0 : (CNT_W'(WIDTH) - lz);

  // Restoring step. rem_q < divisor, so rem_shift < 2*divisor and the
  // top bit of the (WIDTH+1)-bit difference is a clean borrow flag.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, dsr_q};
  assign take      = ~diff[WIDTH];

  // Final results. Divide-by-zero returns all ones and the raw dividend.
  assign q_fin = b_zero ? '1   : ((a_neg ^ b_neg) ? -dvd_q : dvd_q);
  assign r_fin = b_zero ? a_q  : (a_neg ? -rem_q : rem_q);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    dvd_d        = dvd_q;
    dsr_d        = dsr_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    wb_rd_d      = wb_rd_q;
    wb_id_d      = wb_id_q;
    stored_quo_d = stored_quo_q;
    stored_rem_d = stored_rem_q;

    case (state_q)
      S_IDLE: begin
        if (new_request && ready) begin
          a_d  = rs1;
          b_d  = rs2;
          op_d = op;
          id_d = instruction_id;
          if (reuse_result) begin
            wb_rd_d = op[1] ? stored_rem_q : stored_quo_q;
            wb_id_d = instruction_id;
            state_d = S_DONE;
          end else begin
            state_d = S_INIT;
          end
        end
      end

      S_INIT: begin
        // Pre-shifting by lz means the N iterations consume exactly the
        // significant dividend bits; the shifted-in zeros end up above the
        // quotient bits, so dvd_q is the quotient magnitude when done.
        dvd_d   = a_zero ? '0 : (a_mag << lz);
        dsr_d   = b_mag;
        rem_d   = '0;
        cnt_d   = n_iter;
        state_d = (n_iter != '0) ? S_DIVIDE : S_SIGN_FIX;
      end

      S_DIVIDE: begin
        rem_d = take ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], take};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_SIGN_FIX;
      end

      S_SIGN_FIX: begin
        stored_quo_d = q_fin;
        stored_rem_d = r_fin;
        wb_rd_d      = op_q[1] ? r_fin : q_fin;
        wb_id_d      = id_q;
        state_d      = S_DONE;
      end

      S_DONE: begin
        if (wb_ack) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a SIGN_FIX in progress: the
    // reuse registers only change once SIGN_FIX has actually retired.
    if (flush) begin
      state_d      = S_IDLE;
      wb_rd_d      = wb_rd_q;
      wb_id_d      = wb_id_q;
      stored_quo_d = stored_quo_q;
      stored_rem_d = stored_rem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      dvd_q        <= '0;
      dsr_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      wb_rd_q      <= '0;
      wb_id_q      <= '0;
      stored_quo_q <= '0;
      stored_rem_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      dvd_q        <= dvd_d;
      dsr_q        <= dsr_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      wb_rd_q      <= wb_rd_d;
      wb_id_q      <= wb_id_d;
      stored_quo_q <= stored_quo_d;
      stored_rem_q <= stored_rem_d;
    end
  end

endmodule

// File: tb/tb_div_unit_param.sv
// Bench for div_unit_param. Two instances share one stimulus bus:
//   sel=0 -> WIDTH=32, ID_W=3, EARLY_TERMINATE=0
//   sel=1 -> WIDTH=16, ID_W=4, EARLY_TERMINATE=1
// Expected results are queued at issue; a monitor pops and compares on each
// accepted writeback.

module tb_div_unit_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        req;
  logic        reuse;
  logic        flush;
  logic        ack;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [3:0]  id;

  logic        ready32, done32;
  logic [31:0] rd32;
  logic [2:0]  id32;
  logic        ready16, done16;
  logic [15:0] rd16;
  logic [3:0]  id16;

  logic        ready_m, done_m;
  logic [31:0] rd_m;
  logic [3:0]  id_m;

  always #5 clk = ~clk;

  div_unit_param #(.WIDTH(32), .ID_W(3), .EARLY_TERMINATE(0)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .new_request(req & ~sel), .ready(ready32),
    .rs1(rs1), .rs2(rs2), .op(op), .reuse_result(reuse),
    .instruction_id(id[2:0]), .flush(flush & ~sel),
    .wb_done(done32), .wb_rd(rd32), .wb_id(id32), .wb_ack(ack & ~sel)
  );

  div_unit_param #(.WIDTH(16), .ID_W(4), .EARLY_TERMINATE(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .new_request(req & sel), .ready(ready16),
    .rs1(rs1[15:0]), .rs2(rs2[15:0]), .op(op), .reuse_result(reuse),
    .instruction_id(id), .flush(flush & sel),
    .wb_done(done16), .wb_rd(rd16), .wb_id(id16), .wb_ack(ack & sel)
  );

  assign ready_m = sel ? ready16 : ready32;
  assign done_m  = sel ? done16  : done32;
  assign rd_m    = sel ? {16'h0, rd16} : rd32;
  assign id_m    = sel ? id16 : {1'b0, id32};

  typedef struct {
    logic [31:0] rd;
    logic [3:0]  id;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a writeback is consumed at the edge where wb_done & wb_ack.
  always @(negedge clk) begin
    if (rst_n && done_m && ack) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: wb_rd %h wb_id %h with nothing expected", rd_m, id_m);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_rd", 64'(rd_m), 64'(e.rd));
        check("wb_id", 64'(id_m), 64'(e.id));
      end
    end
  end

  // Issue one request; called just after a rising edge.
  task automatic issue(input logic s, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic ru, input logic [3:0] tag,
                       input int ack_dly, input int exp_lat, input logic [31:0] exp_rd);
    int n;
    int cyc;
    logic [31:0] rd0;
    logic [3:0]  id0;
    sel = s;
    n = 0;
    #0;
    while (!ready_m && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_m) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: ready stayed %b", ready_m);
      return;
    end
    op = o; rs1 = a; rs2 = b; reuse = ru; id = tag; req = 1'b1;
    sb_q.push_back('{rd: exp_rd, id: tag});
    @(posedge clk); #1;
    req = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done_m && cyc < 200);
    if (!done_m) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: wb_done %b after %0d cycles", done_m, cyc);
      return;
    end
    if (exp_lat >= 0) check("latency", 64'(cyc), 64'(exp_lat));
    rd0 = rd_m;
    id0 = id_m;
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      check("bp_hold", {26'h0, done_m, ready_m, rd_m, id_m}, {26'h0, 1'b1, 1'b0, rd0, id0});
    end
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic model16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output int lat);
    longint sa, sb, lq, lr;
    logic [15:0] mag;
    int bl;
    if (b == 16'h0) begin
      q = 16'hFFFF;
      r = a;
    end else begin
      if (!o[0]) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[15:0];
      r  = lr[15:0];
    end
    mag = (!o[0] && a[15]) ? (16'h0 - a) : a;
    bl = 0;
    for (int i = 0; i < 16; i++) if (mag[i]) bl = i + 1;
    lat = (b == 16'h0 || mag == 16'h0) ? 3 : bl + 3;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int seen;
    logic [15:0] ra, rb, rq, rr, last_q, last_r;
    logic [1:0]  ro;
    logic [3:0]  rid;
    int          rlat;
    logic [15:0] corner [6];

    rst_n = 1'b0; sel = 1'b0; req = 1'b0; reuse = 1'b0; flush = 1'b0; ack = 1'b0;
    op = 2'b00; rs1 = '0; rs2 = '0; id = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready32", 64'(ready32), 64'd1);
    check("rst_done32",  64'(done32),  64'd0);
    check("rst_rd32",    64'(rd32),    64'd0);
    check("rst_id32",    64'(id32),    64'd0);
    check("rst_ready16", 64'(ready16), 64'd1);
    check("rst_rd16",    64'(rd16),    64'd0);
    @(posedge clk); #1;

    // WIDTH=32, no early termination
    issue(0, 2'b00, 32'd20,         32'd6,          0, 4'd1, 0, 35, 32'd3);
    issue(0, 2'b00, 32'hFFFFFFEC,   32'hFFFFFFFD,   0, 4'd2, 0, 35, 32'd6);
    issue(0, 2'b00, 32'hFFFFFFEC,   32'd6,          0, 4'd3, 0, 35, 32'hFFFFFFFD);
    issue(0, 2'b01, 32'hFFFFFFEC,   32'd6,          0, 4'd4, 0, 35, 32'd715827879);
    issue(0, 2'b01, 32'd20,         32'hFFFFFFFA,   0, 4'd5, 0, 35, 32'd0);
    issue(0, 2'b00, 32'h80000000,   32'hFFFFFFFF,   0, 4'd6, 0, 35, 32'h80000000);
    issue(0, 2'b10, 32'h80000000,   32'hFFFFFFFF,   0, 4'd7, 0, 35, 32'd0);
    issue(0, 2'b10, 32'hFFFFFFEC,   32'd6,          0, 4'd0, 0, 35, 32'hFFFFFFFE);
    issue(0, 2'b10, 32'd20,         32'hFFFFFFFA,   0, 4'd1, 0, 35, 32'd2);
    issue(0, 2'b11, 32'hFFFFFFEC,   32'd6,          0, 4'd2, 0, 35, 32'd2);
    issue(0, 2'b11, 32'hFFFFFFEC,   32'hFFFFFFFA,   0, 4'd3, 0, 35, 32'hFFFFFFEC);
    // divide by zero
    issue(0, 2'b00, 32'd0,          32'd0,          0, 4'd4, 0, 3,  32'hFFFFFFFF);
    issue(0, 2'b01, 32'd1,          32'd0,          0, 4'd5, 0, 3,  32'hFFFFFFFF);
    issue(0, 2'b10, 32'h80000000,   32'd0,          0, 4'd6, 0, 3,  32'h80000000);
    issue(0, 2'b11, 32'd1,          32'd0,          0, 4'd7, 0, 3,  32'd1);
    issue(0, 2'b00, 32'd0,          32'd5,          0, 4'd0, 0, -1, 32'd0);
    // back-pressure: 10 cycles without ack
    issue(0, 2'b00, 32'd100,        32'd7,          0, 4'd5, 10, 35, 32'd14);
    // reuse
    issue(0, 2'b11, 32'd20,         32'd6,          0, 4'd1, 0, 35, 32'd2);
    issue(0, 2'b10, 32'd20,         32'd6,          1, 4'd2, 0, 1,  32'd2);
    issue(0, 2'b00, 32'd20,         32'd6,          1, 4'd3, 0, 1,  32'd3);

    // flush during the 5th DIVIDE cycle (cycle 6 after the accept edge)
    sel = 0; op = 2'b00; rs1 = 32'd1000; rs2 = 32'd3; reuse = 0; id = 4'd4; req = 1;
    @(posedge clk); #1;
    req = 0;
    repeat (5) @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    check("flush_ready", 64'(ready_m), 64'd0);
    check("flush_done",  64'(done_m),  64'd0);
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("ready_after_flush", 64'(ready_m), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_m) seen++;
    end
    check("no_wb_after_flush", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(0, 2'b00, 32'd20,         32'd6,          1, 4'd5, 0, 1,  32'd3);
    issue(0, 2'b10, 32'd20,         32'd6,          1, 4'd6, 0, 1,  32'd2);

    // flush together with a request in IDLE: must not be accepted
    sel = 0; op = 2'b00; reuse = 1; id = 4'd7; req = 1; flush = 1;
    @(negedge clk);
    check("flush_idle_ready", 64'(ready_m), 64'd0);
    @(posedge clk); #1;
    req = 0; flush = 0; reuse = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_m) seen++;
    end
    check("flush_idle_no_wb", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // WIDTH=16, early termination
    issue(1, 2'b01, 32'd5,          32'd3,          0, 4'd9,  0, 6,  32'd1);
    issue(1, 2'b00, 32'h8000,       32'hFFFF,       0, 4'd10, 0, 19, 32'h8000);
    issue(1, 2'b00, 32'd0,          32'd7,          0, 4'd11, 0, 3,  32'd0);
    issue(1, 2'b10, 32'hFFEC,       32'd6,          0, 4'd12, 0, 8,  32'hFFFE);
    last_q = 16'hFFFD;
    last_r = 16'hFFFE;

    corner[0] = 16'h0000; corner[1] = 16'h0001; corner[2] = 16'hFFFF;
    corner[3] = 16'h8000; corner[4] = 16'h7FFF; corner[5] = 16'h0002;
    for (int t = 0; t < 2000; t++) begin
      ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      ro  = 2'($urandom_range(0, 3));
      rid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        issue(1, ro, {16'h0, ra}, {16'h0, rb}, 1, rid, int'($urandom_range(0, 15)), 1,
              {16'h0, (ro[1] ? last_r : last_q)});
      end else begin
        model16(ro, ra, rb, rq, rr, rlat);
        issue(1, ro, {16'h0, ra}, {16'h0, rb}, 0, rid, int'($urandom_range(0, 15)), rlat,
              {16'h0, (ro[1] ? rr : rq)});
        last_q = rq;
        last_r = rr;
      end
    end

    // reset in the middle of a divide: result lost, reuse registers cleared
    sel = 0; op = 2'b00; rs1 = 32'd20; rs2 = 32'd6; reuse = 0; id = 4'd3; req = 1;
    @(posedge clk); #1;
    req = 0;
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    check("rst_mid_done", 64'(done_m), 64'd0);
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_m) seen++;
    end
    check("rst_mid_no_wb", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(0, 2'b00, 32'd20, 32'd6, 1, 4'd2, 0, 1, 32'd0);

    repeat (3) @(posedge clk);
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
